// File: rtl/addsub_pkg.sv
// Shared types and sizing for the bit-serial adder/subtractor.
package addsub_pkg;

  // Sequencer states: wait for a request, walk the bits, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

endpackage : addsub_pkg

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder; the carry flop lives in the parent.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Plain sum / majority carry.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : serial_fa_cell

// File: rtl/serial_addsub_8.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a
// single full-adder cell. Subtract is a + ~b + 1, so co=1 means no borrow.
module serial_addsub_8
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             of
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             cell_s;
  logic             cell_co;
  logic             last_bit;
  logic             c_msb;

  serial_fa_cell u_cell (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // On the MSB cycle the carry register holds the carry into the MSB.
  always_comb begin
    last_bit = (cnt == LAST);
    c_msb    = carry;
  end

  // Sequencer, datapath shift registers and registered result/handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      of    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : ci;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= {cell_s, r_sh[WIDTH-1:1]};
          carry <= cell_co;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            // Publish the completed word; the partial R never reaches s.
            s     <= {cell_s, r_sh[WIDTH-1:1]};
            co    <= cell_co;
            of    <= c_msb ^ cell_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // start is deliberately not sampled here.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_addsub_8

// File: tb/tb_serial_addsub_8.sv
// Directed bench for serial_addsub_8.
module tb_serial_addsub_8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         ci = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         of;

  int checks = 0;
  int errors = 0;

  serial_addsub_8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .ci    (ci),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .of    (of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check handshake timing and the result.
  task automatic run_op(input string tag, input logic op_sub, input logic op_ci,
                        input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic [W-1:0] exp_s, input logic exp_co, input logic exp_of);
    @(negedge clk);
    sub = op_sub; ci = op_ci; a = op_a; b = op_b; start = 1'b1;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    check({tag, " busy after E0"}, 32'(busy), 32'd1);
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;                     // E1..E7
      check({tag, " no early done"}, 32'(done), 32'd0);
    end
    @(posedge clk); #1;                       // E8
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy low"}, 32'(busy), 32'd0);
    check({tag, " s"}, 32'(s), 32'(exp_s));
    check({tag, " co"}, 32'(co), 32'(exp_co));
    check({tag, " of"}, 32'(of), 32'(exp_of));
    @(posedge clk); #1;
    check({tag, " done one cycle"}, 32'(done), 32'd0);
    check({tag, " s held"}, 32'(s), 32'(exp_s));
  endtask

  initial begin
    // Reset state
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset s", 32'(s), 32'd0);
    check("reset co", 32'(co), 32'd0);
    check("reset of", 32'(of), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("add 7f+01",    1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op("add ff+01",    1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("add 10+20+1",  1'b0, 1'b1, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0);
    run_op("sub 05-03",    1'b1, 1'b0, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0);
    run_op("sub 00-01",    1'b1, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
    run_op("sub 80-01",    1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    run_op("add 80+80",    1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

    // Held start with operands churning during RUN.
    @(negedge clk);
    sub = 1'b0; ci = 1'b0; a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1;                       // E0
    check("hold busy", 32'(busy), 32'd1);
    for (int i = 1; i < W; i++) begin
      a = 8'(i * 37); b = 8'(i * 91); sub = i[0];
      @(posedge clk); #1;
      check("hold no early done", 32'(done), 32'd0);
    end
    a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;                       // E8
    check("hold done", 32'(done), 32'd1);
    check("hold s", 32'(s), 32'h33);
    check("hold co", 32'(co), 32'd0);
    sub = 1'b0; a = 8'h01; b = 8'h02;
    @(posedge clk); #1;                       // E9: DONE, start ignored
    check("start in DONE ignored", 32'(busy), 32'd0);
    check("done cleared", 32'(done), 32'd0);
    @(posedge clk); #1;                       // E10: IDLE, accepted
    check("start in IDLE accepted", 32'(busy), 32'd1);
    start = 1'b0;
    for (int i = 1; i < W; i++) @(posedge clk);
    #1;
    check("reissue no early done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("reissue done", 32'(done), 32'd1);
    check("reissue s", 32'(s), 32'h03);

    // Reset mid-operation.
    @(negedge clk);
    sub = 1'b0; ci = 1'b0; a = 8'h0F; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort s cleared", 32'(s), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort co", 32'(co), 32'd0);
    check("abort of", 32'(of), 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    begin
      int pulses = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (done) pulses++;
      end
      check("abort no done", 32'(pulses), 32'd0);
    end
    run_op("after abort 0f+01", 1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_addsub_8
